ag_mem_reader: RTL

- Consumer-side counterpart of the LDPC address counter.
- Walks a contiguous address window [base_addr, base_addr+length-1] of a synchronous message RAM (1-cycle read latency) and streams the read words out on a valid/ready interface.
- Backpressure is absorbed by a 2-entry skid FIFO, so reads never overrun the consumer.
- Sits between the variable/check-node message memories and the node processing units in the LDPC decoder datapath.

---
 rtl/ag_mem_reader_pkg.sv | 13 +
 rtl/ag_skid_fifo.sv | 65 ++++++
 rtl/ag_mem_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ag_mem_reader_pkg.sv
// Shared types for the LDPC message-memory reader.
// FSM encoding and skid FIFO depth.
package ag_mem_reader_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

endpackage

// File: rtl/ag_skid_fifo.sv
// Two-entry shift FIFO; head entry is the registered output.
// Simultaneous push/pop allowed whenever the FIFO is non-empty.
module ag_skid_fifo
  import ag_mem_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] s0_q, s0_d;
  logic [W-1:0] s1_q, s1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;
  logic [1:0]   wr_idx;

  always_comb begin
    pop_ok  = pop_i && (cnt_q != 2'd0);
    push_ok = push_i &&
              ((cnt_q != 2'(FIFO_DEPTH)) || pop_ok);
    wr_idx  = cnt_q - {1'b0, pop_ok};
    s0_d    = s0_q;
    s1_d    = s1_q;
    if (pop_ok) begin
      s0_d = s1_q;
    end
    // A push lands behind whatever survives the pop.
    if (push_ok) begin
      if (wr_idx == 2'd0) begin
        s0_d = din_i;
      end else begin
        s1_d = din_i;
      end
    end
    cnt_d = cnt_q + {1'b0, push_ok}
                  - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q  <= '0;
      s1_q  <= '0;
      cnt_q <= '0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = s0_q;
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == 2'(FIFO_DEPTH));
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ag_mem_reader.sv
// Streams a contiguous window of a 1-cycle-latency RAM
// onto a valid/ready port, throttled by a 2-entry skid FIFO.
module ag_mem_reader
  import ag_mem_reader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int LW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     issued_q, issued_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic              fire;
  logic              issue;
  logic              issue_last;
  logic [2:0]        committed;
  logic              f_full;
  logic              f_empty;
  logic [1:0]        f_count;
  logic [DATA_W:0]   f_dout;

  assign fire = out_valid && out_ready;

  // Words already owed to the FIFO, net of this cycle's pop.
  assign committed = {1'b0, f_count}
                   + {2'b00, infl_q}
                   - {2'b00, fire};

  assign issue = (state_q == RUN) &&
                 (committed < 3'(FIFO_DEPTH)) &&
                 !(f_full && !fire);

  assign issue_last = issue &&
                      (issued_q == len_q - LW'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    beat_d      = beat_q;
    infl_d      = issue;
    infl_last_d = issue_last;
    done_d      = 1'b0;
    if (issue) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + LW'(1);
    end
    if (fire) begin
      beat_d = beat_q + LW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          beat_d   = '0;
          if (length == '0) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Stay here through the done cycle so busy covers it.
        if (done_q) begin
          state_d = IDLE;
        end else if (fire &&
                     beat_q == len_q - LW'(1)) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      beat_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      beat_q      <= beat_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  ag_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (infl_q),
    .pop_i   (fire),
    .din_i   ({infl_last_q, mem_rd_data}),
    .dout_o  (f_dout),
    .count_o (f_count),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign out_valid = !f_empty;
  assign out_data  = f_dout[DATA_W-1:0];
  assign out_last  = f_dout[DATA_W] && !f_empty;

endmodule
